// File: rtl/demux5bit_1to2_buffered.sv
// Buffered 1-to-2 demultiplexer: one valid/ready input steered by in_sel into two
// independent DEPTH-entry FIFOs. Optional per-output delivery counters under DEMUX_STATS_EN.
module demux5bit_1to2_buffered #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned DEPTH = 2
`ifdef DEMUX_STATS_EN
  , parameter int unsigned CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready
`ifdef DEMUX_STATS_EN
  , output logic [CNT_W-1:0] cnt0
  , output logic [CNT_W-1:0] cnt1
`endif
);

  localparam int unsigned PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_BITS = PTR_W + 1;
  localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(DEPTH);

  logic [WIDTH-1:0]    mem_q    [2][DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q [2];
  logic [PTR_W-1:0]    wr_ptr_d [2];
  logic [PTR_W-1:0]    rd_ptr_q [2];
  logic [PTR_W-1:0]    rd_ptr_d [2];
  logic [CNT_BITS-1:0] count_q  [2];
  logic [CNT_BITS-1:0] count_d  [2];
  logic                full_c   [2];
  logic                push_c   [2];
  logic                pop_c    [2];
  logic                oready_c [2];

  assign oready_c[0] = out0_ready;
  assign oready_c[1] = out1_ready;

  // Ready depends only on the selected FIFO; no bypass, so full refuses even on a same-cycle pop.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      full_c[n] = (count_q[n] == FULL_CNT);
    end
    in_ready = !reset && !full_c[in_sel];
    for (int n = 0; n < 2; n++) begin
      push_c[n]   = in_valid && in_ready && (in_sel == 1'(n));
      pop_c[n]    = (count_q[n] != '0) && oready_c[n];
      wr_ptr_d[n] = wr_ptr_q[n] + PTR_W'(push_c[n]);
      rd_ptr_d[n] = rd_ptr_q[n] + PTR_W'(pop_c[n]);
      count_d[n]  = count_q[n] + CNT_BITS'(push_c[n]) - CNT_BITS'(pop_c[n]);
    end
  end

  // FIFO state and storage; reset discards everything buffered.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < 2; n++) begin
        wr_ptr_q[n] <= '0;
        rd_ptr_q[n] <= '0;
        count_q[n]  <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          mem_q[n][i] <= '0;
        end
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        wr_ptr_q[n] <= wr_ptr_d[n];
        rd_ptr_q[n] <= rd_ptr_d[n];
        count_q[n]  <= count_d[n];
        if (push_c[n]) begin
          mem_q[n][wr_ptr_q[n]] <= in_data;
        end
      end
    end
  end

  assign out0_valid = (count_q[0] != '0);
  assign out1_valid = (count_q[1] != '0);
  assign out0_data  = mem_q[0][rd_ptr_q[0]];
  assign out1_data  = mem_q[1][rd_ptr_q[1]];

`ifdef DEMUX_STATS_EN
  logic [CNT_W-1:0] stat_q [2];
  logic [CNT_W-1:0] stat_d [2];

  // Saturating per-output delivery counters.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      stat_d[n] = stat_q[n];
      if (pop_c[n] && (stat_q[n] != '1)) begin
        stat_d[n] = stat_q[n] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < 2; n++) begin
        stat_q[n] <= '0;
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        stat_q[n] <= stat_d[n];
      end
    end
  end

  assign cnt0 = stat_q[0];
  assign cnt1 = stat_q[1];
`endif

endmodule
